// File: rtl/ecg_hybrid_decoder.sv
// ecg_hybrid_decoder
// Receive-side decompressor for the hybrid run-length / Golomb-Rice ECG
// stream. Each accepted codeword is either a run token (N repeats of the
// current predictor) or a GR codeword (k=3/4/5) whose signed delta is
// accumulated onto the predictor. Reconstructed samples leave through a
// single-slot valid/ready output register.
//
// Optional build macro: DEC_SAT_EN
//   defined   -> pred+delta saturates to the signed SMP_W range
//   undefined -> pred+delta wraps modulo 2^SMP_W
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   pred_clr   in   synchronous pulse, predictor <= 0 (also aborts a run)
//   cw_valid   in   codeword valid
//   cw_ready   out  codeword can be accepted this cycle
//   cw_type    in   0=run token, 1/2/3 = GR k=3/4/5
//   cw_data    in   codeword, LSB-aligned
//   smp_valid  out  output sample valid
//   smp_ready  in   sink accepts sample
//   smp_data   out  reconstructed signed sample
//   err        out  one-cycle pulse on a zero-length run token
//
// state   | meaning
// ST_IDLE | accepting codewords (when the output slot is free)
// ST_RUN  | emitting the remaining samples of a run token

module ecg_hybrid_decoder #(
    parameter int SMP_W = 16,
    parameter int Q_W   = 6,
    parameter int RUN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pred_clr,
    input  logic             cw_valid,
    output logic             cw_ready,
    input  logic [1:0]       cw_type,
    input  logic [11:0]      cw_data,
    output logic             smp_valid,
    input  logic             smp_ready,
    output logic [SMP_W-1:0] smp_data,
    output logic             err
);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    localparam int A_W = SMP_W + 2;

    state_t             r_state, w_nxt_state;
    logic [SMP_W-1:0]   r_pred, w_nxt_pred;
    logic [SMP_W-1:0]   r_smp_data, w_nxt_data;
    logic               r_smp_valid, w_nxt_valid;
    logic               r_err, w_nxt_err;
    logic [RUN_W-1:0]   r_cnt, w_nxt_cnt;

    logic               w_slot_free;
    logic               w_xfer;
    logic [RUN_W-1:0]   w_run_n;
    logic               w_sign;
    logic signed [A_W-1:0] w_mag, w_delta, w_base, w_sum;
    logic [SMP_W-1:0]   w_res;
    logic [SMP_W-1:0]   w_pred_eff;

    assign w_slot_free = !r_smp_valid || smp_ready;
    assign cw_ready    = (r_state == ST_IDLE) && w_slot_free;
    assign w_xfer      = cw_valid && cw_ready;
    assign w_run_n     = cw_data[RUN_W-1:0];

    // A same-cycle clear takes effect before the codeword is decoded.
    assign w_pred_eff  = pred_clr ? '0 : r_pred;

    always_comb begin
        w_mag  = '0;
        w_sign = 1'b0;
        unique case (cw_type)
            2'd1: begin
                w_mag  = A_W'({cw_data[Q_W+3:4], cw_data[2:0]});
                w_sign = cw_data[3];
            end
            2'd2: begin
                w_mag  = A_W'({cw_data[Q_W+4:5], cw_data[3:0]});
                w_sign = cw_data[4];
            end
            2'd3: begin
                w_mag  = A_W'({cw_data[Q_W+5:6], cw_data[4:0]});
                w_sign = cw_data[5];
            end
            default: begin
                w_mag  = '0;
                w_sign = 1'b0;
            end
        endcase
    end

    assign w_delta = w_sign ? -w_mag : w_mag;
    assign w_base  = A_W'($signed(w_pred_eff));
    assign w_sum   = w_base + w_delta;

`ifdef DEC_SAT_EN
    // Out of range whenever the three top bits disagree.
    always_comb begin
        w_res = w_sum[SMP_W-1:0];
        if (w_sum[A_W-1:SMP_W-1] != 3'b000 && w_sum[A_W-1:SMP_W-1] != 3'b111)
            w_res = w_sum[A_W-1] ? {1'b1, {(SMP_W-1){1'b0}}} : {1'b0, {(SMP_W-1){1'b1}}};
    end
`else
    assign w_res = w_sum[SMP_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_nxt_state;
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_pred  = w_pred_eff;
        w_nxt_cnt   = r_cnt;
        w_nxt_data  = r_smp_data;
        w_nxt_valid = r_smp_valid && !smp_ready;
        w_nxt_err   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    if (cw_type == 2'd0) begin
                        if (w_run_n == '0) begin
                            w_nxt_err = 1'b1;
                        end else begin
                            w_nxt_data  = w_pred_eff;
                            w_nxt_valid = 1'b1;
                            w_nxt_cnt   = w_run_n - RUN_W'(1);
                            if (w_run_n != RUN_W'(1))
                                w_nxt_state = ST_RUN;
                        end
                    end else begin
                        w_nxt_data  = w_res;
                        w_nxt_pred  = w_res;
                        w_nxt_valid = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (pred_clr) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_cnt   = '0;
                end else if (w_slot_free) begin
                    w_nxt_data  = r_pred;
                    w_nxt_valid = 1'b1;
                    w_nxt_cnt   = r_cnt - RUN_W'(1);
                    if (r_cnt == RUN_W'(1))
                        w_nxt_state = ST_IDLE;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred      <= '0;
            r_smp_data  <= '0;
            r_smp_valid <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_pred      <= w_nxt_pred;
            r_smp_data  <= w_nxt_data;
            r_smp_valid <= w_nxt_valid;
            r_err       <= w_nxt_err;
            r_cnt       <= w_nxt_cnt;
        end
    end

    assign smp_valid = r_smp_valid;
    assign smp_data  = r_smp_data;
    assign err       = r_err;

endmodule

// File: tb/tb_ecg_hybrid_decoder.sv
// Directed self-checking bench for ecg_hybrid_decoder.
module tb_ecg_hybrid_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pred_clr;
    logic        cw_valid;
    logic        cw_ready;
    logic [1:0]  cw_type;
    logic [11:0] cw_data;
    logic        smp_valid;
    logic        smp_ready;
    logic [15:0] smp_data;
    logic        err;

    int checks   = 0;
    int failures = 0;

    ecg_hybrid_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pred_clr  (pred_clr),
        .cw_valid  (cw_valid),
        .cw_ready  (cw_ready),
        .cw_type   (cw_type),
        .cw_data   (cw_data),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .smp_data  (smp_data),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Waits for cw_ready at a falling edge, presents one codeword for one
    // rising edge, then withdraws it.
    task automatic send(input logic clr, input logic [1:0] t, input logic [11:0] d);
        int n = 0;
        @(negedge clk);
        while (!cw_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cw_ready) chk("cw_ready_timeout", 0, 1);
        pred_clr = clr;
        cw_valid = 1'b1;
        cw_type  = t;
        cw_data  = d;
        @(posedge clk);
        #1;
        cw_valid = 1'b0;
        pred_clr = 1'b0;
        cw_type  = 2'd0;
        cw_data  = 12'h000;
    endtask

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    int cnt;
    int exp_ovf;

    initial begin
        rst_n = 1'b0; pred_clr = 1'b0; cw_valid = 1'b0;
        cw_type = 2'd0; cw_data = 12'h000; smp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_smp_valid", int'(smp_valid), 0);
        chk("rst_smp_data", s16(smp_data), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_cw_ready", int'(cw_ready), 1);
        rst_n = 1'b1;

        // GR k=3: q=2 s=0 r=5 -> +21
        send(1'b0, 2'd1, 12'h025);
        @(negedge clk);
        chk("gr3_valid", int'(smp_valid), 1);
        chk("gr3_data", s16(smp_data), 21);

        // GR k=4: q=1 s=1 r=3 -> -19, pred 2
        send(1'b0, 2'd2, 12'h033);
        @(negedge clk);
        chk("gr4_data", s16(smp_data), 2);

        // Run N=3, sink always ready
        send(1'b0, 2'd0, 12'h003);
        @(negedge clk);
        chk("run3_s1", s16(smp_data), 2);
        chk("run3_rdy1", int'(cw_ready), 0);
        @(negedge clk);
        chk("run3_s2_valid", int'(smp_valid), 1);
        chk("run3_s2", s16(smp_data), 2);
        chk("run3_rdy2", int'(cw_ready), 0);
        @(negedge clk);
        chk("run3_s3_valid", int'(smp_valid), 1);
        chk("run3_s3", s16(smp_data), 2);
        chk("run3_rdy3", int'(cw_ready), 1);
        @(negedge clk);
        chk("run3_drain", int'(smp_valid), 0);

        // Run N=5 with a 4-cycle stall after the first sample
        send(1'b0, 2'd0, 12'h005);
        cnt = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            smp_ready = (i < 1 || i > 4);
            if (smp_valid && smp_ready) begin
                cnt++;
                chk("run5_data", s16(smp_data), 2);
            end
            if (!smp_ready) begin
                chk("run5_stall_valid", int'(smp_valid), 1);
                chk("run5_stall_data", s16(smp_data), 2);
            end
        end
        smp_ready = 1'b1;
        chk("run5_count", cnt, 5);
        chk("run5_idle_ready", int'(cw_ready), 1);

        // Zero-length run
        send(1'b0, 2'd0, 12'h000);
        @(negedge clk);
        chk("run0_err", int'(err), 1);
        chk("run0_no_smp", int'(smp_valid), 0);
        @(negedge clk);
        chk("run0_err_pulse", int'(err), 0);
        send(1'b0, 2'd1, 12'h025);
        @(negedge clk);
        chk("after_err_gr", s16(smp_data), 23);

        // Build pred = 32760: 16 x 2047 then +8, then +2047 overflow
        send(1'b1, 2'd3, 12'hFDF);
        for (int i = 0; i < 15; i++) send(1'b0, 2'd3, 12'hFDF);
        @(negedge clk);
        chk("acc_32752", s16(smp_data), 32752);
        send(1'b0, 2'd1, 12'h010);
        @(negedge clk);
        chk("acc_32760", s16(smp_data), 32760);
`ifdef DEC_SAT_EN
        exp_ovf = 32767;
`else
        exp_ovf = -30729;
`endif
        send(1'b0, 2'd3, 12'hFDF);
        @(negedge clk);
        chk("ovf_result", s16(smp_data), exp_ovf);

        // pred_clr aborts a run
        send(1'b1, 2'd1, 12'h025);
        send(1'b0, 2'd0, 12'h00A);
        @(negedge clk);
        chk("abort_first", s16(smp_data), 21);
        pred_clr = 1'b1;
        @(posedge clk);
        #1;
        pred_clr = 1'b0;
        @(negedge clk);
        chk("abort_drained", int'(smp_valid), 0);
        chk("abort_ready", int'(cw_ready), 1);
        send(1'b0, 2'd1, 12'h025);
        @(negedge clk);
        chk("abort_gr_from_zero", s16(smp_data), 21);

        // Async reset mid-run
        send(1'b0, 2'd0, 12'h0C8);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", int'(smp_valid), 0);
        chk("rst_mid_ready", int'(cw_ready), 1);
        @(negedge clk);
        chk("rst_held_valid", int'(smp_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_after_valid", int'(smp_valid), 0);
        send(1'b1, 2'd1, 12'h025);
        @(negedge clk);
        chk("rst_gr_valid", int'(smp_valid), 1);
        chk("rst_gr_data", s16(smp_data), 21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
